pc_redirect_unit: RTL and testbench

Fetch-side consumer of the execute-stage condition result: takes the condition-gated branch-taken and PC-write signals and steers the fetch PC. It raises the pipeline flushes, holds a redirect target while fetch is stalled, and counts taken redirects. It sits between the conditional unit (execute/writeback) and the PC register in fetch.

---
 rtl/pc_redirect_pkg.sv | 34 +++
 rtl/sat_counter.sv | 32 +++
 rtl/pc_redirect_unit.sv | 97 +++++++++
 tb/tb_pc_redirect_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pc_redirect_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_redirect_pkg
//  Description : Shared state encoding and flush masks for the PC redirect unit.
//  Revision    : 1.0
// ============================================================================
package pc_redirect_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } redirect_state_t;

    // Flush mask bit order is {FlushM, FlushE, FlushD}.
    localparam int          c_flush_w      = 3;
    localparam logic [2:0]  c_flush_none   = 3'b000;
    localparam logic [2:0]  c_flush_branch = 3'b011;
    localparam logic [2:0]  c_flush_pcsrc  = 3'b111;
    localparam logic [2:0]  c_flush_reset  = 3'b111;

    // A writeback PC write is older than the execute branch, so it dominates.
    function automatic logic [c_flush_w-1:0] flush_mask(input logic pcsrc,
                                                        input logic branch);
        logic [c_flush_w-1:0] mask;
        mask = c_flush_none;
        if (pcsrc)
            mask = c_flush_pcsrc;
        else if (branch)
            mask = c_flush_branch;
        return mask;
    endfunction

endpackage : pc_redirect_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Enable-driven up counter that sticks at all-ones.
//  Revision    : 1.0
// ============================================================================
module sat_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          en,
    output logic [CW-1:0] count
);

    logic [CW-1:0] r_count;
    logic          w_at_max;

    assign w_at_max = &r_count;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_count <= '0;
        end else if (en && !w_at_max) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pc_redirect_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_redirect_unit
//  Description : Steers the fetch PC on resolved redirects, raises pipeline
//                flushes and parks a target while fetch is stalled.
//  Revision    : 1.0
// ============================================================================
module pc_redirect_unit
    import pc_redirect_pkg::*;
#(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter int           CW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          BranchTakenE,
    input  logic [N-1:0]  BranchTargetE,
    input  logic          PCSrcW,
    input  logic [N-1:0]  ResultW,
    input  logic [N-1:0]  PCPlus4F,
    input  logic          StallF,
    output logic [N-1:0]  PCNextF,
    output logic          FlushD,
    output logic          FlushE,
    output logic          FlushM,
    output logic          RedirectPending,
    output logic [CW-1:0] TakenCount
);

    redirect_state_t      r_state;
    logic [N-1:0]         r_held_target;
    logic                 r_pending;

    logic                 w_event;
    logic [N-1:0]         w_target;
    logic [c_flush_w-1:0] w_flush;
    logic [N-1:0]         w_pc_next;

    assign w_event  = PCSrcW | BranchTakenE;
    assign w_target = PCSrcW ? ResultW : BranchTargetE;

    // State, held target and the pending flag move together so the flag is
    // a clean register output rather than a decode of the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_held_target <= '0;
            r_pending     <= 1'b0;
        end else begin
            if (w_event && StallF) begin
                r_state       <= HOLD;
                r_held_target <= w_target;
                r_pending     <= 1'b1;
            end else if (w_event || !StallF) begin
                r_state       <= IDLE;
                r_pending     <= 1'b0;
            end
        end
    end

    // The PC register ignores PCNextF while stalled, so a stalled event only
    // needs to be captured, not presented.
    always_comb begin
        w_pc_next = PCPlus4F;
        w_flush   = c_flush_none;
        if (!rst) begin
            w_pc_next = RESET_PC;
            w_flush   = c_flush_reset;
        end else begin
            w_flush = flush_mask(PCSrcW, BranchTakenE);
            if (w_event) begin
                if (!StallF)
                    w_pc_next = w_target;
            end else if (r_state == HOLD) begin
                w_pc_next = r_held_target;
            end
        end
    end

    assign PCNextF         = w_pc_next;
    assign FlushD          = w_flush[0];
    assign FlushE          = w_flush[1];
    assign FlushM          = w_flush[2];
    assign RedirectPending = r_pending;

    sat_counter #(
        .CW    (CW)
    ) u_taken_counter (
        .clk   (clk),
        .clr_n (rst),
        .en    (w_event),
        .count (TakenCount)
    );

endmodule : pc_redirect_unit
`default_nettype wire

// File: tb/tb_pc_redirect_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_redirect_unit
//  Description : Directed plus random stimulus against a behavioural model of
//                the redirect rules.
//  Revision    : 1.0
// ============================================================================
module tb_pc_redirect_unit;

    localparam int          N        = 32;
    localparam int          CW       = 4;
    localparam logic [N-1:0] RST_PC  = 32'h0;
    localparam int          CNT_MAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          BranchTakenE = 1'b0;
    logic [N-1:0]  BranchTargetE = '0;
    logic          PCSrcW = 1'b0;
    logic [N-1:0]  ResultW = '0;
    logic [N-1:0]  PCPlus4F = '0;
    logic          StallF = 1'b0;
    logic [N-1:0]  PCNextF;
    logic          FlushD, FlushE, FlushM, RedirectPending;
    logic [CW-1:0] TakenCount;

    int checks   = 0;
    int failures = 0;

    // Model: is a redirect parked, where does it go, how many redirects seen.
    bit            m_parked;
    logic [N-1:0]  m_parked_pc;
    int            m_redirects;

    always #5 clk = ~clk;

    pc_redirect_unit #(
        .N        (N),
        .RESET_PC (RST_PC),
        .CW       (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .BranchTakenE    (BranchTakenE),
        .BranchTargetE   (BranchTargetE),
        .PCSrcW          (PCSrcW),
        .ResultW         (ResultW),
        .PCPlus4F        (PCPlus4F),
        .StallF          (StallF),
        .PCNextF         (PCNextF),
        .FlushD          (FlushD),
        .FlushE          (FlushE),
        .FlushM          (FlushM),
        .RedirectPending (RedirectPending),
        .TakenCount      (TakenCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pc"},      PCNextF, RST_PC);
        chk({tag, "_flushD"},  32'(FlushD), 32'd1);
        chk({tag, "_flushE"},  32'(FlushE), 32'd1);
        chk({tag, "_flushM"},  32'(FlushM), 32'd1);
        chk({tag, "_pending"}, 32'(RedirectPending), 32'd0);
        chk({tag, "_count"},   32'(TakenCount), 32'd0);
    endtask

    // Called just after a rising edge: drive, check mid-cycle, advance model.
    task automatic step(input string tag, input logic pcsrc, input logic [N-1:0] res,
                        input logic bt, input logic [N-1:0] btgt,
                        input logic [N-1:0] p4, input logic st);
        logic [N-1:0] want_pc;
        logic [N-1:0] tgt;
        bit           redirect;
        bit           pc_defined;
        PCSrcW = pcsrc; ResultW = res; BranchTakenE = bt; BranchTargetE = btgt;
        PCPlus4F = p4; StallF = st;
        #2;
        redirect   = pcsrc || bt;
        tgt        = pcsrc ? res : btgt;
        pc_defined = 1'b1;
        if (redirect) begin
            if (!st)           want_pc = tgt;
            else if (m_parked) begin want_pc = '0; pc_defined = 1'b0; end
            else               want_pc = p4;
        end else begin
            want_pc = m_parked ? m_parked_pc : p4;
        end
        if (pc_defined) chk({tag, "_pc"}, PCNextF, want_pc);
        chk({tag, "_flushD"},  32'(FlushD), 32'(redirect));
        chk({tag, "_flushE"},  32'(FlushE), 32'(redirect));
        chk({tag, "_flushM"},  32'(FlushM), 32'(pcsrc));
        chk({tag, "_pending"}, 32'(RedirectPending), 32'(m_parked));
        chk({tag, "_count"},   32'(TakenCount), 32'(m_redirects));
        @(posedge clk);
        if (redirect) begin
            m_redirects = (m_redirects < CNT_MAX) ? m_redirects + 1 : CNT_MAX;
            m_parked    = st;
            if (st) m_parked_pc = tgt;
        end else if (!st) begin
            m_parked = 1'b0;
        end
        #1;
    endtask

    task automatic model_clear();
        m_parked    = 1'b0;
        m_parked_pc = '0;
        m_redirects = 0;
    endtask

    initial begin
        model_clear();
        // Held in reset across several edges.
        PCPlus4F = 32'h104;
        #2;
        chk_reset_outputs("rst_init");
        @(posedge clk); @(posedge clk); #1;
        chk_reset_outputs("rst_held");
        rst = 1'b1;

        step("idle",      1'b0, 32'h0,   1'b0, 32'h0,   32'h104, 1'b0);
        step("branch",    1'b0, 32'h0,   1'b1, 32'h200, 32'h108, 1'b0);
        step("both",      1'b1, 32'h300, 1'b1, 32'h200, 32'h10c, 1'b0);
        step("after_two", 1'b0, 32'h0,   1'b0, 32'h0,   32'h304, 1'b0);

        // Stalled branch parks its target until StallF drops.
        step("hold_cap",  1'b0, 32'h0,   1'b1, 32'h400, 32'h308, 1'b1);
        step("hold_1",    1'b0, 32'h0,   1'b0, 32'h0,   32'h308, 1'b1);
        step("hold_2",    1'b0, 32'h0,   1'b0, 32'h0,   32'h308, 1'b1);
        step("hold_rel",  1'b0, 32'h0,   1'b0, 32'h0,   32'h308, 1'b0);
        step("post_rel",  1'b0, 32'h0,   1'b0, 32'h0,   32'h404, 1'b0);

        // Newer redirect while parked replaces the old target.
        step("repl_cap",  1'b0, 32'h0,   1'b1, 32'h400, 32'h408, 1'b1);
        step("repl_new",  1'b1, 32'h500, 1'b0, 32'h0,   32'h408, 1'b1);
        step("repl_rel",  1'b0, 32'h0,   1'b0, 32'h0,   32'h408, 1'b0);

        // Reset mid-HOLD drops pending at once and loses the target.
        step("mid_cap",   1'b0, 32'h0,   1'b1, 32'h600, 32'h504, 1'b1);
        PCSrcW = 1'b0; BranchTakenE = 1'b0; StallF = 1'b1;
        #1;
        chk("mid_pre_pending", 32'(RedirectPending), 32'd1);
        rst = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        model_clear();
        @(posedge clk); #1;
        rst = 1'b1;
        step("mid_after", 1'b0, 32'h0,   1'b0, 32'h0,   32'h508, 1'b0);

        // Saturation: 2^CW + 3 redirects.
        for (int i = 0; i < CNT_MAX + 4; i++)
            step("sat", 1'b0, 32'h0, 1'b1, 32'h700 + 32'(i * 4), 32'h800, 1'b0);
        chk("sat_final", 32'(TakenCount), 32'(CNT_MAX));

        // Random traffic.
        rst = 1'b0;
        #1;
        model_clear();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 3) == 0),
                 {$urandom, 2'b00} & 32'hffff_fffc,
                 ($urandom_range(0, 2) == 0),
                 {$urandom, 2'b00} & 32'hffff_fffc,
                 {$urandom, 2'b00} & 32'hffff_fffc,
                 ($urandom_range(0, 9) < 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pc_redirect_unit
`default_nettype wire
